// File: rtl/logic_sweep_ctrl.sv
// Deterministic truth-table sweep of a small combinational datapath: step every
// input vector, let it settle for DWELL cycles, capture d_in, compare to a golden table.
module logic_sweep_ctrl #(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned DWELL = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [(1<<N_IN)-1:0]   expected,
  input  logic                   d_in,
  output logic [N_IN-1:0]        vec_out,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   truth_tbl,
  output logic                   mismatch,
  output logic [N_IN-1:0]        err_idx
);

  localparam int unsigned NV = 1 << N_IN;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [NV-1:0]   exp_q, exp_d;
  logic [NV-1:0]   tbl_q, tbl_d;
  logic            mm_q, mm_d;
  logic [N_IN-1:0] err_q, err_d;
  logic [NV-1:0]   diff;
  logic [N_IN-1:0] first_diff;

  assign diff = tbl_q ^ exp_q;

  // Scan from the top so the lowest differing index is the last one written.
  always_comb begin
    first_diff = '0;
    for (int unsigned i = 0; i < NV; i++) begin
      if (diff[NV-1-i]) first_diff = N_IN'(NV - 1 - i);
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    tbl_d   = tbl_q;
    mm_d    = mm_q;
    err_d   = err_q;
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
      vec_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_d = SETTLE;
            vec_d   = '0;
            cnt_d   = '0;
            exp_d   = expected;
            tbl_d   = '0;
          end
        end
        SETTLE: begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'(DWELL - 1)) state_d = SAMPLE;
        end
        SAMPLE: begin
          tbl_d[vec_q] = d_in;
          cnt_d        = '0;
          if (vec_q == N_IN'(NV - 1)) begin
            state_d = DONE;
          end else begin
            vec_d   = vec_q + N_IN'(1);
            state_d = SETTLE;
          end
        end
        DONE: begin
          mm_d    = |diff;
          err_d   = first_diff;
          vec_d   = '0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      tbl_q   <= '0;
      mm_q    <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      tbl_q   <= tbl_d;
      mm_q    <= mm_d;
      err_q   <= err_d;
    end
  end

  assign busy      = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done      = (state_q == DONE);
  assign vec_out   = busy ? vec_q : '0;
  assign truth_tbl = tbl_q;
  assign mismatch  = mm_q;
  assign err_idx   = err_q;

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// Bench for logic_sweep_ctrl: three instances (3/4, 2/4, 3/1) driven from random
// truth tables and checked cycle by cycle against an arithmetic timing model.
module tb_logic_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, abort;
  logic [2:0] st;
  logic [7:0] exp0, exp2, fn0, fn2;
  logic [3:0] exp1, fn1;
  logic       d0, d1, d2;
  logic [2:0] vec0, vec2, err0, err2;
  logic [1:0] vec1, err1;
  logic [7:0] tt0, tt2;
  logic [3:0] tt1;
  logic [2:0] busy, done, mm;

  assign d0 = fn0[vec0];
  assign d1 = fn1[vec1];
  assign d2 = fn2[vec2];

  logic_sweep_ctrl #(.N_IN(3), .DWELL(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .abort(abort), .expected(exp0), .d_in(d0),
    .vec_out(vec0), .busy(busy[0]), .done(done[0]), .truth_tbl(tt0), .mismatch(mm[0]), .err_idx(err0));
  logic_sweep_ctrl #(.N_IN(2), .DWELL(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .abort(abort), .expected(exp1), .d_in(d1),
    .vec_out(vec1), .busy(busy[1]), .done(done[1]), .truth_tbl(tt1), .mismatch(mm[1]), .err_idx(err1));
  logic_sweep_ctrl #(.N_IN(3), .DWELL(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .abort(abort), .expected(exp2), .d_in(d2),
    .vec_out(vec2), .busy(busy[2]), .done(done[2]), .truth_tbl(tt2), .mismatch(mm[2]), .err_idx(err2));

  logic [31:0] vec_w [3];
  logic [31:0] tt_w  [3];
  logic [31:0] err_w [3];
  assign vec_w[0] = 32'(vec0);
  assign vec_w[1] = 32'(vec1);
  assign vec_w[2] = 32'(vec2);
  assign tt_w[0]  = 32'(tt0);
  assign tt_w[1]  = 32'(tt1);
  assign tt_w[2]  = 32'(tt2);
  assign err_w[0] = 32'(err0);
  assign err_w[1] = 32'(err1);
  assign err_w[2] = 32'(err2);

  int unsigned nv [3] = '{8, 4, 8};
  int unsigned dw [3] = '{4, 4, 1};
  logic [31:0] fn_m  [3];
  logic [31:0] ex_m  [3];
  logic [31:0] mm_m  [3];
  logic [31:0] err_m [3];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] lowest_diff(input logic [31:0] a, input logic [31:0] b,
                                              input int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      if (a[i] != b[i]) return 32'(i);
    return 32'd0;
  endfunction

  task automatic drive_ports();
    fn0  = fn_m[0][7:0];
    fn1  = fn_m[1][3:0];
    fn2  = fn_m[2][7:0];
    exp0 = ex_m[0][7:0];
    exp1 = ex_m[1][3:0];
    exp2 = ex_m[2][7:0];
  endtask

  task automatic randomize_tables();
    for (int k = 0; k < 3; k++) begin
      logic [31:0] mask;
      mask    = (32'd1 << nv[k]) - 32'd1;
      fn_m[k] = $urandom & mask;
      case ($urandom_range(0, 2))
        0:       ex_m[k] = fn_m[k];
        1:       ex_m[k] = fn_m[k] ^ (32'd1 << $urandom_range(0, nv[k] - 1));
        default: ex_m[k] = $urandom & mask;
      endcase
    end
  endtask

  task automatic check_cycle(input int k, input int unsigned c, input bit hold);
    int unsigned t, cc;
    logic [31:0] b, v, dn;
    t  = nv[k] * (dw[k] + 1);
    cc = hold ? ((c - 1) % (t + 2)) + 1 : c;
    if (cc <= t) begin
      b = 1; v = 32'((cc - 1) / (dw[k] + 1)); dn = 0;
    end else if (cc == t + 1) begin
      b = 0; v = 0; dn = 1;
    end else begin
      b = 0; v = 0; dn = 0;
    end
    // Comparison result becomes visible the cycle after DONE.
    if (c == t + 2) begin
      mm_m[k]  = 32'(fn_m[k] != ex_m[k]);
      err_m[k] = lowest_diff(fn_m[k], ex_m[k], nv[k]);
    end
    check($sformatf("busy%0d c%0d", k, c), 32'(busy[k]), b);
    check($sformatf("vec%0d c%0d", k, c), vec_w[k], v);
    check($sformatf("done%0d c%0d", k, c), 32'(done[k]), dn);
    check($sformatf("mm%0d c%0d", k, c), 32'(mm[k]), mm_m[k]);
  endtask

  task automatic run_sweep(input logic [2:0] which, input bit hold, input int unsigned cycles);
    drive_ports();
    @(negedge clk);
    st = which;
    @(posedge clk); #1;
    if (!hold) st = '0;
    exp0 = 8'($urandom);
    exp1 = 4'($urandom);
    exp2 = 8'($urandom);
    for (int unsigned c = 1; c <= cycles; c++) begin
      for (int k = 0; k < 3; k++)
        if (which[k]) check_cycle(k, c, hold);
      @(posedge clk); #1;
    end
    st = '0;
    for (int k = 0; k < 3; k++) begin
      if (which[k]) begin
        if (!hold) check($sformatf("tt%0d", k), tt_w[k], fn_m[k]);
        check($sformatf("mm%0d", k), 32'(mm[k]), mm_m[k]);
        check($sformatf("err%0d", k), err_w[k], err_m[k]);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s busy%0d", tag, k), 32'(busy[k]), 0);
      check($sformatf("%s done%0d", tag, k), 32'(done[k]), 0);
      check($sformatf("%s vec%0d", tag, k), vec_w[k], 0);
      check($sformatf("%s tt%0d", tag, k), tt_w[k], 0);
      check($sformatf("%s mm%0d", tag, k), 32'(mm[k]), 0);
      check($sformatf("%s err%0d", tag, k), err_w[k], 0);
    end
  endtask

  task automatic abort_test();
    @(negedge clk);
    st    = 3'b111;
    abort = 1'b1;
    @(posedge clk); #1;
    st    = '0;
    abort = 1'b0;
    for (int k = 0; k < 3; k++) check($sformatf("start_abort_idle busy%0d", k), 32'(busy[k]), 0);
    randomize_tables();
    drive_ports();
    @(negedge clk);
    st = 3'b111;
    @(posedge clk); #1;
    st = '0;
    for (int unsigned c = 1; c <= 10; c++) begin
      for (int k = 0; k < 3; k++) check_cycle(k, c, 1'b0);
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("abort busy%0d", k), 32'(busy[k]), 0);
      check($sformatf("abort vec%0d", k), vec_w[k], 0);
    end
    for (int unsigned c = 0; c < 45; c++) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("post_abort done%0d", k), 32'(done[k]), 0);
        check($sformatf("post_abort busy%0d", k), 32'(busy[k]), 0);
        check($sformatf("post_abort mm%0d", k), 32'(mm[k]), mm_m[k]);
        check($sformatf("post_abort err%0d", k), err_w[k], err_m[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    abort = 1'b0;
    st    = '0;
    for (int k = 0; k < 3; k++) begin
      fn_m[k] = 0; ex_m[k] = 0; mm_m[k] = 0; err_m[k] = 0;
    end
    drive_ports();
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // d = (a|b)&c on the 3-input instances, d = a&b on the 2-input one.
    fn_m = '{32'hA8, 32'h8, 32'hA8};
    ex_m = '{32'hA8, 32'h8, 32'hA8};
    run_sweep(3'b111, 1'b0, 42);
    ex_m = '{32'hA9, 32'h9, 32'hA9};
    run_sweep(3'b111, 1'b0, 42);
    ex_m = '{32'hE8, 32'hC, 32'hE8};
    run_sweep(3'b111, 1'b0, 42);
    check("directed err_idx E8", 32'(err0), 32'd6);

    repeat (6) begin
      randomize_tables();
      run_sweep(3'b111, 1'b0, 42);
    end

    abort_test();

    // Start held through a whole sweep restarts only once IDLE is reached.
    randomize_tables();
    run_sweep(3'b001, 1'b1, 43);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("hold_abort busy0", 32'(busy[0]), 0);

    randomize_tables();
    drive_ports();
    @(negedge clk);
    st = 3'b111;
    @(posedge clk); #1;
    st = '0;
    repeat (25) @(posedge clk);
    #1;
    check("pre_reset vec0", 32'(vec0), 5);
    #2;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mm_m[k] = 0; err_m[k] = 0;
    end
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    randomize_tables();
    run_sweep(3'b111, 1'b0, 42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
